handshake_sink: RTL and testbench
=================================

# handshake_sink

Clocked consumer at the tail of the self-timed stage_combine chain. It accepts words over the chain's four-phase valid/ack handshake and synchronises `valid_in` into the `clk` domain. It buffers up to two words and presents them to synchronous logic on a valid/ready interface. This is the block that drains the FIFO pipeline into the clocked system.

## Interface
- `data_width`, 3: word width, matching the stage chain.
- `sync_stages`, 2: flip-flop depth of the `valid_in` synchroniser (≥2).
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `valid_in`  in  1: request from the last stage (its `valid_out`); asynchronous to `clk`.
- `data_in`  in  data_width: bundled data from the last stage; stable while `valid_in` is high and until `ack_out` is seen.
- `ack_out`  out  1: acknowledge to the last stage (drives its `ack_in`); registered.
- `out_valid`  out  1: buffer head holds a word.
- `out_data`  out  data_width: buffer head word.
- `out_ready`  in  1: consumer takes the head when `out_valid` and `out_ready` are both high.
- `xfer_count`  out  8: words accepted since reset; wraps modulo 256.

## Operation
- Synchroniser: `valid_in` passes through `sync_stages` flip-flops. The last flip-flop's output is `vs`. Nothing else samples `valid_in` directly.
- FSM has two states: IDLE (`ack_out`=0) and ACK (`ack_out`=1). `ack_out` is high exactly when the state is ACK.
- IDLE → ACK when `vs`=1 and `count`<2.
  - On that edge, `data_in` is written at the buffer tail and `xfer_count` is incremented.
  - If `vs`=1 and `count`=2, the block stays in IDLE with no capture. The upstream chain is stalled by the withheld ack.
- ACK → IDLE when `vs`=0 (return-to-zero seen). No capture happens in ACK, whatever `data_in` does.
- A new capture needs `vs` to go 0 then 1 again, so each four-phase cycle yields exactly one word.
- Buffer: 2-entry circular FIFO with `rd_ptr`, `wr_ptr` (1 bit each) and `count` (0..2).
  - `out_valid` = (`count`≠0).
  - `out_data` = `mem[rd_ptr]`, a registered read of the head.
  - Pop: `out_valid`&`out_ready`. The pointer advances and `count` is decremented.
  - Push and pop on the same edge leave `count` unchanged and both pointers advance.
  - Full condition: the capture test uses the registered `count` only. When full, a pop on that edge does not enable a same-edge push; the capture happens one edge later.
  - Empty condition: `out_ready` while `count`=0 has no effect.
- `xfer_count` wraps from 255 to 0 without a flag.
- Reset (`rst`=1 at an edge) forces the following on that edge, including mid-handshake:
  - state IDLE, `ack_out`=0;
  - synchroniser flip-flops 0;
  - `count`, pointers and `xfer_count` 0;
  - `out_valid`=0, `out_data`=0, memory cleared.
- Buffered words are discarded on reset. If upstream still holds `valid_in` high after reset, that word is captured again once synchronised. This is the required behaviour.

## Timing
- Take E0 as the first edge that samples `valid_in`=1 (default `sync_stages`=2):
  - E0: first synchroniser flip-flop = 1.
  - E1: `vs`=1.
  - E2: capture. After E2, `ack_out`=1 and `out_valid`=1 (if the buffer was empty).
- In general, `ack_out` rises `sync_stages` edges after E0.
- Release: `valid_in` falls and is first sampled low at edge F0. `vs`=0 after F0+`sync_stages`−1, and `ack_out` falls on the next edge. Release latency is therefore `sync_stages` edges after F0.
- Minimum period per word is 2·`sync_stages`+2 edges, plus the upstream stage delays.
- `out_data`/`out_valid` update only on edges. A pop on edge N makes the next word (if any) visible after N.
- `data_in` is sampled at the capture edge only. It has been stable for ≥`sync_stages` cycles by then, per the bundled-data rule.

## Test plan
- Single word: `rst` 2 cycles, drive `valid_in`=1 with `data_in`=5, and hold `out_ready`=0 → after the 3rd sampling edge, `ack_out`=1, `out_valid`=1, `out_data`=5, `xfer_count`=1. Drop `valid_in` → `ack_out`=0 two edges later.
- Streaming: drive words 1,2,3,4 with a four-phase upstream model, `out_ready`=1 → consumer sees 1,2,3,4 in order, none duplicated, `xfer_count`=4.
- Backpressure: `out_ready`=0, offer 6,7,0 → 6 and 7 are acked and `count`=2. For word 0, `ack_out` stays 0 indefinitely. Raise `out_ready` for one cycle → 6 is popped, 0 is captured one edge later, and the consumer then sees 7,0.
- Full plus pop on the same edge: `count`=2, `vs`=1 and `out_ready`=1 → the capture edge is one cycle after the pop, and `xfer_count` increments once.
- Reset mid-handshake: assert `rst` while in ACK with 1 word buffered → next edge `ack_out`=0, `out_valid`=0, `xfer_count`=0. With `valid_in` still high, the word is recaptured 2 edges after `rst` is released.
- Wrap: transfer 257 words → `xfer_count`=1, with the data order intact.

Source files
------------

// File: rtl/handshake_sink.sv
// handshake_sink: clocked tail of the self-timed stage_combine chain.
// Latency: ack_out and out_valid rise sync_stages edges after valid_in is first sampled high.
// Backpressure: with two words buffered the ack is withheld, stalling the upstream chain.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   valid_in, data_in   - four-phase request and bundled data from the last stage (async)
//   ack_out             - registered four-phase acknowledge back to the last stage
//   out_valid, out_data - head of the 2-entry buffer (valid/ready side)
//   out_ready           - consumer accepts the head when out_valid is also high
//   xfer_count          - words accepted since reset, wraps modulo 256
module handshake_sink #(
  parameter int data_width  = 3,
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [data_width-1:0] data_in,
  output logic                  ack_out,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ready,
  output logic [7:0]            xfer_count
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                state;
  logic [sync_stages-1:0] sync_q;
  logic                  vs;

  logic [data_width-1:0] mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  capture;
  logic                  pop;
  logic                  rd_nxt;
  logic [data_width-1:0] head_nxt;

  // valid_in is only ever sampled by the first synchroniser flop.
  assign vs = sync_q[sync_stages-1];

  assign out_valid = (count != 2'd0);

  always_comb begin
    // Capture uses the registered count only: a pop on a full buffer does
    // not open a slot for the same edge.
    capture  = (state == IDLE) && vs && (count < 2'd2);
    pop      = out_valid && out_ready;
    rd_nxt   = rd_ptr ^ pop;
    // The head register must show the word landing this edge when the
    // write goes straight into the slot that becomes the head.
    head_nxt = mem[rd_nxt];
    if (capture && (wr_ptr == rd_nxt)) begin
      head_nxt = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack_out    <= 1'b0;
      sync_q     <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      xfer_count <= 8'd0;
      out_data   <= '0;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], valid_in};

      case (state)
        IDLE: begin
          if (capture) begin
            state   <= ACK;
            ack_out <= 1'b1;
          end
        end
        ACK: begin
          // Wait for the return-to-zero before another word can be taken.
          if (!vs) begin
            state   <= IDLE;
            ack_out <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ack_out <= 1'b0;
        end
      endcase

      if (capture) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ~wr_ptr;
        xfer_count  <= xfer_count + 8'd1;
      end

      rd_ptr   <= rd_nxt;
      out_data <= head_nxt;

      case ({capture, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_sink.sv
// Scoreboard bench for handshake_sink: a four-phase upstream model feeds
// directed words, expected words are queued at issue time and a negedge
// monitor checks every word the consumer accepts.
module tb_handshake_sink;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [2:0] data_in;
  logic       ack_out;
  logic       out_valid;
  logic [2:0] out_data;
  logic       out_ready;
  logic [7:0] xfer_count;

  int checks;
  int failures;
  int exp_q[$];

  handshake_sink #(.data_width(3), .sync_stages(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ack_out    (ack_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Full four-phase transfer of one word from the upstream model.
  task automatic send(input logic [2:0] w);
    int n;
    exp_q.push_back(int'(w));
    data_in  = w;
    valid_in = 1'b1;
    n = 0;
    while (!ack_out && n < 60) begin step(); n++; end
    if (!ack_out) check("send_ack_rise_timeout", 0, 1);
    valid_in = 1'b0;
    n = 0;
    while (ack_out && n < 60) begin step(); n++; end
    if (ack_out) check("send_ack_fall_timeout", 1, 0);
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin step(); n++; end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: a word is accepted on the next rising edge whenever
  // out_valid and out_ready are both high mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", int'(out_data), -1);
      end else begin
        check("word_order", int'(out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = 3'd0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_ack", int'(ack_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_xfer", int'(xfer_count), 0);

    // Single word: capture on the third sampling edge, release two edges after F0
    data_in  = 3'd5;
    valid_in = 1'b1;
    exp_q.push_back(5);
    steps(2);
    check("single_ack_before_e2", int'(ack_out), 0);
    step();
    check("single_ack", int'(ack_out), 1);
    check("single_out_valid", int'(out_valid), 1);
    check("single_out_data", int'(out_data), 5);
    check("single_xfer", int'(xfer_count), 1);
    valid_in = 1'b0;
    step();
    step();
    check("single_ack_hold_f1", int'(ack_out), 1);
    step();
    check("single_ack_fall_f2", int'(ack_out), 0);
    drain("single_drain");
    out_ready = 1'b0;

    // Streaming with consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(3'(i));
    drain("stream_drain");
    check("stream_xfer", int'(xfer_count), 4);

    // Backpressure and full-plus-pop on the same edge
    do_reset();
    out_ready = 1'b0;
    send(3'd6);
    send(3'd7);
    data_in  = 3'd0;
    valid_in = 1'b1;
    exp_q.push_back(0);
    steps(12);
    check("bp_ack_withheld", int'(ack_out), 0);
    check("bp_xfer_full", int'(xfer_count), 2);
    check("bp_out_data_head", int'(out_data), 6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_no_capture_on_pop_edge", int'(ack_out), 0);
    check("bp_head_after_pop", int'(out_data), 7);
    step();
    check("bp_capture_next_edge", int'(ack_out), 1);
    check("bp_xfer_after", int'(xfer_count), 3);
    valid_in = 1'b0;
    steps(4);
    check("bp_xfer_once", int'(xfer_count), 3);
    drain("bp_drain");

    // Reset mid-handshake with one word buffered
    do_reset();
    out_ready = 1'b0;
    data_in   = 3'd3;
    valid_in  = 1'b1;
    steps(3);
    check("mid_ack_before_rst", int'(ack_out), 1);
    rst = 1'b1;
    step();
    exp_q.delete();
    check("mid_rst_ack", int'(ack_out), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_xfer", int'(xfer_count), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    exp_q.push_back(3);
    steps(2);
    check("mid_recap_not_yet", int'(ack_out), 0);
    step();
    check("mid_recap_ack", int'(ack_out), 1);
    check("mid_recap_xfer", int'(xfer_count), 1);
    check("mid_recap_data", int'(out_data), 3);
    valid_in = 1'b0;
    steps(4);
    drain("mid_drain");

    // Wrap: 257 transfers bring the counter back to 1
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) send(3'(i % 7));
    drain("wrap_drain");
    check("wrap_xfer", int'(xfer_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
